// File: rtl/sb_pkg.sv
// Store buffer shared types: FSM state encoding, default geometry, entry payload.
package sb_pkg;

  localparam int unsigned SB_DEPTH_DEF  = 4;
  localparam int unsigned SB_ADDR_W_DEF = 32;
  localparam int unsigned SB_DATA_W     = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOAD  = 2'd2
  } sb_state_e;

  // Address field is sized to the default word-address width.
  typedef struct packed {
    logic [SB_ADDR_W_DEF-1:0] addr;
    logic [SB_DATA_W-1:0]     data;
  } sb_entry_t;

endpackage

// File: rtl/sb_match.sv
// Youngest-first address match over the live store-buffer entries.
// Returns the slot index of the most recently enqueued entry whose address
// equals i_addr. Only instantiated when STORE_FWD_EN is defined.
module sb_match #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0]        i_addrs [DEPTH],
  input  logic [$clog2(DEPTH)-1:0] i_tail,
  input  logic [$clog2(DEPTH):0]   i_count,
  input  logic [ADDR_W-1:0]        i_addr,
  output logic                     o_hit,
  output logic [$clog2(DEPTH)-1:0] o_idx
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // Scan oldest-to-youngest so the youngest match is the last one written.
  always_comb begin
    logic [PTR_W-1:0] v_idx;
    o_hit = 1'b0;
    o_idx = '0;
    v_idx = '0;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      v_idx = PTR_W'(i_tail - PTR_W'(k) - PTR_W'(1));
      if ((CNT_W'(k) < i_count) && (i_addrs[v_idx] == i_addr)) begin
        o_hit = 1'b1;
        o_idx = v_idx;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between the memory stage and a single-port dmem.
// Stores are queued in a circular FIFO and drained to dmem in program order;
// loads either wait for the buffer to empty (default) or, with STORE_FWD_EN
// defined, take data from the youngest matching entry and bypass
// non-matching stores on a miss.
module store_buffer
  import sb_pkg::*;
#(
  parameter int unsigned DEPTH  = SB_DEPTH_DEF,
  parameter int unsigned ADDR_W = SB_ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_data,
  input  logic              cpu_wren,
  input  logic              cpu_rden,
  output logic [31:0]       cpu_q,
  output logic              cpu_stall,
  output logic              mem_req,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_q
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  sb_entry_t        r_entry [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  sb_state_e        r_state;
  sb_state_e        w_state_nxt;

  logic        w_full;
  logic        w_load_req;
  logic        w_fwd_hit;
  logic [31:0] w_fwd_data;
  logic        w_load_miss;
  logic        w_load_go;
  logic        w_load_done;
  logic        w_enq;
  logic        w_pop;

  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign w_load_req  = cpu_rden & ~cpu_wren;
  assign w_load_done = (r_state == ST_LOAD) & mem_ack;

`ifdef STORE_FWD_EN
  logic [ADDR_W-1:0] w_match_addr [DEPTH];
  logic              w_match_hit;
  logic [PTR_W-1:0]  w_match_idx;

  // Present the stored addresses to the comparator bank.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_match_addr[i] = ADDR_W'(r_entry[i].addr);
    end
  end

  sb_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_match (
    .i_addrs (w_match_addr),
    .i_tail  (r_tail),
    .i_count (r_count),
    .i_addr  (cpu_addr),
    .o_hit   (w_match_hit),
    .o_idx   (w_match_idx)
  );

  assign w_fwd_hit   = w_load_req & w_match_hit;
  assign w_fwd_data  = r_entry[w_match_idx].data;
  assign w_load_miss = w_load_req & ~w_match_hit;
  assign w_load_go   = w_load_miss;
`else
  assign w_fwd_hit   = 1'b0;
  assign w_fwd_data  = '0;
  assign w_load_miss = w_load_req;
  assign w_load_go   = w_load_req & (r_count == '0);
`endif

  // Stall on a full buffer (even if a drain ack lands this cycle) or an
  // outstanding load miss until its data returns; forced low in reset.
  assign cpu_stall = reset & ((cpu_wren & w_full) | (w_load_miss & ~w_load_done));

  assign w_enq = cpu_wren & ~cpu_stall;
  assign w_pop = (r_state == ST_DRAIN) & mem_ack;

  // Load data: dmem return on LOAD completion, otherwise forwarded entry.
  always_comb begin
    cpu_q = '0;
    if (w_load_done) begin
      cpu_q = mem_q;
    end else if (w_fwd_hit) begin
      cpu_q = w_fwd_data;
    end
  end

  // dmem request decode straight from the state register.
  always_comb begin
    mem_req   = 1'b0;
    mem_wren  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      ST_DRAIN: begin
        mem_req   = 1'b1;
        mem_wren  = 1'b1;
        mem_addr  = ADDR_W'(r_entry[r_head].addr);
        mem_wdata = r_entry[r_head].data;
      end
      ST_LOAD: begin
        mem_req  = 1'b1;
        mem_addr = cpu_addr;
      end
      default: ;
    endcase
  end

  // Next-state: a pending load takes priority over draining.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_load_go) begin
          w_state_nxt = ST_LOAD;
        end else if (r_count != '0) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: if (mem_ack) w_state_nxt = ST_IDLE;
      ST_LOAD:  if (mem_ack) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop keep count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + PTR_W'(1);
      if (w_pop) r_head <= r_head + PTR_W'(1);
      case ({w_enq, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; occupancy alone defines which slots are live.
  always_ff @(posedge clock) begin
    if (w_enq) begin
      r_entry[r_tail] <= '{addr: SB_ADDR_W_DEF'(cpu_addr), data: cpu_data};
    end
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered store entries (power of two, 2..16).
REQ-002 Parameter ADDR_W, default 32, dmem word-address width.
REQ-003 clock  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; asserting it clears all state immediately.
REQ-005 cpu_addr  input  ADDR_W  memory-stage word address.
REQ-006 cpu_data  input  32  memory-stage store data.
REQ-007 cpu_wren  input  1  memory-stage store request.
REQ-008 cpu_rden  input  1  memory-stage load request.
REQ-009 cpu_q  output  32  load data returned to the writeback latch.
REQ-010 cpu_stall  output  1  freezes all pipeline latches while high.
REQ-011 mem_req  output  1  dmem transaction request.
REQ-012 mem_wren  output  1  1 = write, 0 = read; valid while mem_req is high.
REQ-013 mem_addr  output  ADDR_W  dmem address; valid while mem_req is high.
REQ-014 mem_wdata  output  32  dmem write data; valid while mem_req is high.
REQ-015 mem_ack  input  1  one-cycle completion pulse; mem_q is valid in that cycle for reads.
REQ-016 mem_q  input  32  dmem read data.

Function
REQ-017 Circular FIFO: head/tail pointers wrap modulo DEPTH; count spans 0..DEPTH.
REQ-018 cpu_wren with cpu_stall low enqueues {cpu_addr, cpu_data} at the tail on that edge; a store arriving while stalled is not enqueued.
REQ-019 cpu_stall asserts combinationally when cpu_wren is high and count==DEPTH, even if a drain ack occurs in the same cycle.
REQ-020 cpu_wren and cpu_rden both high: treat as a store, ignore the read.
REQ-021 FSM states: IDLE, DRAIN, LOAD.
REQ-022 IDLE with a pending load miss goes to LOAD; otherwise IDLE with count>0 goes to DRAIN; otherwise it stays in IDLE.
REQ-023 DRAIN: mem_req=1, mem_wren=1, head entry on mem_addr/mem_wdata, held stable until mem_ack; on mem_ack pop head, go to IDLE.
REQ-024 LOAD: mem_req=1, mem_wren=0, mem_addr=cpu_addr; on mem_ack cpu_q=mem_q, cpu_stall=0 in that cycle, go to IDLE.
REQ-025 A load miss holds cpu_stall high from the first request cycle through the cycle before mem_ack, including while a drain it waits behind completes.
REQ-026 Enqueue and drain-pop in the same cycle leave count unchanged.
REQ-027 Loads bypass older non-matching stores; stores reach dmem strictly in program order.
REQ-028 Reset during DRAIN or LOAD abandons the transaction: mem_req drops immediately and buffered stores are discarded.

Reset
REQ-029 While reset is low: head=tail=count=0, state=IDLE, mem_req=0, mem_wren=0, cpu_stall=0, cpu_q=0.

Configuration
REQ-030 With STORE_FWD_EN defined: on a load, the youngest entry whose address equals cpu_addr drives cpu_q combinationally in the same cycle, with no stall and no dmem read.
REQ-031 Without STORE_FWD_EN: a load stalls until count==0 and the FSM is in IDLE, then issues a LOAD. No address comparators are synthesized.

Structure
REQ-032 Package sb_pkg holds the FSM state enum, default DEPTH/ADDR_W, and the entry struct {addr, data}.
REQ-033 Sub-module sb_match is a youngest-first priority address match returning hit and index; it is instantiated only under STORE_FWD_EN.

Verification
REQ-034 Store 0x10<-0xAAAA, then load 0x10 the next cycle, with STORE_FWD_EN: cpu_q=0xAAAA in the same cycle, cpu_stall=0, mem_req never read.
REQ-035 Stores 0x20<-1 then 0x20<-2, then load 0x20: forwarded cpu_q=2 (youngest entry wins).
REQ-036 Five stores with DEPTH=4, mem_ack held low: fifth store sees cpu_stall=1; after one mem_ack the fifth enqueues; dmem sees writes in issue order.
REQ-037 Load 0x40 miss while a DRAIN is outstanding: drain completes first; LOAD issues with mem_addr=0x40; mem_q=0x1234 on ack gives cpu_q=0x1234 and stall drops in that cycle.
REQ-038 Assert reset mid-DRAIN with 3 entries buffered: mem_req=0 immediately, count=0; no dmem write follows release.
REQ-039 Without STORE_FWD_EN, store 0x10 then load 0x10: stall until drain ack, then dmem read of 0x10.
